// File: rtl/icache.sv
// icache: direct-mapped instruction cache with 16-byte lines, dual-slot responses and uncached bypass.
module icache #(
  parameter int SETS = 64
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             inst_rreq_to_icache,
  input  logic [31:0]      pi_pc,
  input  logic [31:0]      pred_addr_in,
  input  logic             pi_is_exception,
  input  logic [6:0]       pi_exception_cause,
  input  logic             iuncache,
  input  logic             flush,
  output logic             icache_pc_suspend,
  output logic             icache_inst_valid,
  output logic             inst_pair_valid,
  output logic [1:0][31:0] pc_for_buffer,
  output logic [1:0][31:0] inst_for_buffer,
  output logic [31:0]      pred_addr_for_buffer,
  output logic             icache_is_exception,
  output logic [6:0]       icache_exception_cause,
  output logic             mem_rd_req,
  output logic [31:0]      mem_rd_addr,
  output logic             mem_rd_burst,
  input  logic             mem_rd_ready,
  input  logic             mem_rdata_valid,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rdata_last
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 28 - IW;
  localparam logic [2:0] IDLE = 3'd0, MISS_REQ = 3'd1, REFILL = 3'd2, UNC_REQ = 3'd3, UNC_WAIT = 3'd4, RESP = 3'd5;
  logic [2:0] state;
  logic [31:0] pc_q, pred_q, addr, slot0, slot1;
  logic cancel, fill, last, unc_done, accept, hit, exc, unc, issue;
  logic [1:0] beat, off;
  logic [IW-1:0] idx;
  logic [SETS-1:0] valid;
  logic [TW-1:0] tags [SETS];
  logic [3:0][31:0] data [SETS];
  logic [3:0][31:0] line;
  logic resp_valid;
  // In IDLE the array is probed with the incoming PC; otherwise with the captured one.
  always_comb begin
    addr = state == IDLE ? pi_pc : pc_q;
    idx = addr[3+IW:4];
    off = addr[3:2];
    fill = state == REFILL && mem_rdata_valid;
    line = data[idx];
    if (fill) line[beat] = mem_rdata;
  end
  assign last = fill && mem_rdata_last;
  assign unc_done = state == UNC_WAIT && mem_rdata_valid;
  assign accept = inst_rreq_to_icache && state == IDLE;
  assign hit = valid[idx] && tags[idx] == addr[31:4+IW];
  assign exc = accept && pi_is_exception;
  assign unc = state == UNC_WAIT;
  assign issue = (accept && (pi_is_exception || (!iuncache && hit))) || ((last || unc_done) && !cancel && !flush);
  assign slot0 = exc ? 32'd0 : unc ? mem_rdata : line[off];
  assign slot1 = (exc || unc || off == 2'd3) ? 32'd0 : line[off + 2'd1];
  assign mem_rd_req = state == MISS_REQ || state == UNC_REQ;
  assign mem_rd_burst = state == MISS_REQ;
  assign mem_rd_addr = state == MISS_REQ ? {pc_q[31:4], 4'b0} : state == UNC_REQ ? pc_q : 32'd0;
  assign icache_pc_suspend = state != IDLE;
  assign icache_inst_valid = resp_valid && !flush;
  always_ff @(posedge cpu_clk) begin
    if (fill) data[idx][beat] <= mem_rdata;
    if (last) tags[idx] <= addr[31:4+IW];
  end
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      state <= IDLE;
      cancel <= 1'b0;
      beat <= 2'd0;
      pc_q <= 32'd0;
      pred_q <= 32'd0;
      valid <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          pc_q <= pi_pc;
          pred_q <= pred_addr_in;
          cancel <= 1'b0;
          state <= pi_is_exception ? IDLE : iuncache ? UNC_REQ : hit ? IDLE : MISS_REQ;
        end
        MISS_REQ: if (mem_rd_ready) begin
          state <= REFILL;
          beat <= 2'd0;
        end
        REFILL: if (fill) begin
          beat <= beat + 2'd1;
          if (mem_rdata_last) begin
            valid[idx] <= 1'b1;
            state <= RESP;
          end
        end
        UNC_REQ: if (mem_rd_ready) state <= UNC_WAIT;
        UNC_WAIT: if (mem_rdata_valid) state <= RESP;
        default: begin
          state <= IDLE;
          cancel <= 1'b0;
        end
      endcase
      // The memory side cannot abort, so a flush only marks the pending response as dead.
      if (flush && state inside {MISS_REQ, REFILL, UNC_REQ, UNC_WAIT}) cancel <= 1'b1;
    end
  end
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      resp_valid <= 1'b0;
      inst_pair_valid <= 1'b0;
      pc_for_buffer <= '0;
      inst_for_buffer <= '0;
      pred_addr_for_buffer <= 32'd0;
      icache_is_exception <= 1'b0;
      icache_exception_cause <= 7'd0;
    end else begin
      resp_valid <= issue;
      if (issue) begin
        inst_pair_valid <= !exc && !unc && off != 2'd3;
        pc_for_buffer <= {addr + 32'd4, addr};
        inst_for_buffer <= {slot1, slot0};
        pred_addr_for_buffer <= state == IDLE ? pred_addr_in : pred_q;
        icache_is_exception <= exc;
        icache_exception_cause <= exc ? pi_exception_cause : 7'd0;
      end
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of hits, misses, uncached fetches, exceptions, flush and reset.
module tb_icache;
  logic cpu_clk, cpu_rst, inst_rreq_to_icache, pi_is_exception, iuncache, flush;
  logic [31:0] pi_pc, pred_addr_in, pred_addr_for_buffer, mem_rd_addr, mem_rdata;
  logic [6:0] pi_exception_cause, icache_exception_cause;
  logic icache_pc_suspend, icache_inst_valid, inst_pair_valid, icache_is_exception;
  logic [1:0][31:0] pc_for_buffer, inst_for_buffer;
  logic mem_rd_req, mem_rd_burst, mem_rd_ready, mem_rdata_valid, mem_rdata_last;
  int n_cmp = 0;
  int n_err = 0;

  icache #(.SETS(64)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst_rreq_to_icache(inst_rreq_to_icache),
    .pi_pc(pi_pc), .pred_addr_in(pred_addr_in), .pi_is_exception(pi_is_exception),
    .pi_exception_cause(pi_exception_cause), .iuncache(iuncache), .flush(flush),
    .icache_pc_suspend(icache_pc_suspend), .icache_inst_valid(icache_inst_valid),
    .inst_pair_valid(inst_pair_valid), .pc_for_buffer(pc_for_buffer),
    .inst_for_buffer(inst_for_buffer), .pred_addr_for_buffer(pred_addr_for_buffer),
    .icache_is_exception(icache_is_exception), .icache_exception_cause(icache_exception_cause),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_burst(mem_rd_burst),
    .mem_rd_ready(mem_rd_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .mem_rdata_last(mem_rdata_last)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] p, input logic u, input logic e);
    pi_pc = p;
    pred_addr_in = p + 32'd8;
    iuncache = u;
    pi_is_exception = e;
    inst_rreq_to_icache = 1'b1;
    tick();
    inst_rreq_to_icache = 1'b0;
    iuncache = 1'b0;
    pi_is_exception = 1'b0;
  endtask

  task automatic burst(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3, input int fb);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = w[k];
      mem_rdata_last = k == 3;
      flush = k == fb;
      tick();
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_last = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    cpu_rst = 1'b0;
    {inst_rreq_to_icache, pi_is_exception, iuncache, flush} = '0;
    {mem_rd_ready, mem_rdata_valid, mem_rdata_last} = '0;
    pi_pc = 32'd0; pred_addr_in = 32'd0; mem_rdata = 32'd0; pi_exception_cause = 7'd0;
    tick(); tick();
    n_cmp++; if (icache_pc_suspend !== 1'b0) begin n_err++; $display("FAIL reset_suspend got %b want 0", icache_pc_suspend); end
    n_cmp++; if (icache_inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", icache_inst_valid); end
    n_cmp++; if ({mem_rd_req, mem_rd_burst, mem_rd_addr} !== 34'd0) begin n_err++; $display("FAIL reset_mem got %b %b %h want 0", mem_rd_req, mem_rd_burst, mem_rd_addr); end
    n_cmp++; if ({pc_for_buffer, inst_for_buffer, pred_addr_for_buffer} !== 160'd0) begin n_err++; $display("FAIL reset_fields got %h %h %h want 0", pc_for_buffer, inst_for_buffer, pred_addr_for_buffer); end
    cpu_rst = 1'b1;
  endtask

  task automatic test_cold_miss;
    fetch(32'h1C000000, 1'b0, 1'b0);
    n_cmp++; if ({mem_rd_req, mem_rd_burst, icache_pc_suspend} !== 3'b111) begin n_err++; $display("FAIL miss_req got req=%b burst=%b susp=%b want 111", mem_rd_req, mem_rd_burst, icache_pc_suspend); end
    n_cmp++; if (mem_rd_addr !== 32'h1C000000) begin n_err++; $display("FAIL miss_addr got %h want 1c000000", mem_rd_addr); end
    burst(32'h11, 32'h22, 32'h33, 32'h44, -1);
    n_cmp++; if ({icache_inst_valid, inst_pair_valid, icache_pc_suspend} !== 3'b111) begin n_err++; $display("FAIL miss_pulse got v=%b pair=%b susp=%b want 111", icache_inst_valid, inst_pair_valid, icache_pc_suspend); end
    n_cmp++; if (inst_for_buffer !== {32'h22, 32'h11}) begin n_err++; $display("FAIL miss_inst got %h want 22/11", inst_for_buffer); end
    n_cmp++; if (pc_for_buffer !== {32'h1C000004, 32'h1C000000}) begin n_err++; $display("FAIL miss_pc got %h want 1c000004/1c000000", pc_for_buffer); end
    n_cmp++; if (pred_addr_for_buffer !== 32'h1C000008) begin n_err++; $display("FAIL miss_pred got %h want 1c000008", pred_addr_for_buffer); end
    tick();
    n_cmp++; if ({icache_inst_valid, icache_pc_suspend} !== 2'b00) begin n_err++; $display("FAIL miss_done got v=%b susp=%b want 00", icache_inst_valid, icache_pc_suspend); end
  endtask

  task automatic test_back_to_back;
    pi_pc = 32'h1C000008;
    inst_rreq_to_icache = 1'b1;
    tick();
    n_cmp++; if ({icache_inst_valid, inst_pair_valid, mem_rd_req, icache_pc_suspend} !== 4'b1100) begin n_err++; $display("FAIL hit_flags got v=%b pair=%b req=%b susp=%b want 1100", icache_inst_valid, inst_pair_valid, mem_rd_req, icache_pc_suspend); end
    n_cmp++; if (inst_for_buffer !== {32'h44, 32'h33}) begin n_err++; $display("FAIL hit_inst got %h want 44/33", inst_for_buffer); end
    pi_pc = 32'h1C00000C;
    tick();
    inst_rreq_to_icache = 1'b0;
    n_cmp++; if ({icache_inst_valid, inst_pair_valid} !== 2'b10) begin n_err++; $display("FAIL lineend_flags got v=%b pair=%b want 10", icache_inst_valid, inst_pair_valid); end
    n_cmp++; if (inst_for_buffer !== {32'h0, 32'h44}) begin n_err++; $display("FAIL lineend_inst got %h want 0/44", inst_for_buffer); end
    tick();
    n_cmp++; if (icache_inst_valid !== 1'b0) begin n_err++; $display("FAIL hit_idle got %b want 0", icache_inst_valid); end
  endtask

  task automatic test_uncached;
    fetch(32'h1FD00000, 1'b1, 1'b0);
    n_cmp++; if ({mem_rd_req, mem_rd_burst} !== 2'b10) begin n_err++; $display("FAIL unc_req got req=%b burst=%b want 10", mem_rd_req, mem_rd_burst); end
    n_cmp++; if (mem_rd_addr !== 32'h1FD00000) begin n_err++; $display("FAIL unc_addr got %h want 1fd00000", mem_rd_addr); end
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 32'hDEAD; mem_rdata_last = 1'b1;
    tick();
    mem_rdata_valid = 1'b0; mem_rdata_last = 1'b0;
    n_cmp++; if ({icache_inst_valid, inst_pair_valid} !== 2'b10) begin n_err++; $display("FAIL unc_flags got v=%b pair=%b want 10", icache_inst_valid, inst_pair_valid); end
    n_cmp++; if (inst_for_buffer !== {32'h0, 32'hDEAD}) begin n_err++; $display("FAIL unc_inst got %h want 0/dead", inst_for_buffer); end
    tick();
    fetch(32'h1FD00000, 1'b0, 1'b0);
    n_cmp++; if ({mem_rd_req, mem_rd_burst} !== 2'b11) begin n_err++; $display("FAIL unc_not_cached got req=%b burst=%b want 11", mem_rd_req, mem_rd_burst); end
    burst(32'hB0, 32'hB1, 32'hB2, 32'hB3, -1);
    tick();
  endtask

  task automatic test_exception;
    pi_exception_cause = 7'h08;
    fetch(32'h1C000000, 1'b0, 1'b1);
    n_cmp++; if ({icache_inst_valid, icache_is_exception, mem_rd_req, icache_pc_suspend} !== 4'b1100) begin n_err++; $display("FAIL exc_flags got v=%b exc=%b req=%b susp=%b want 1100", icache_inst_valid, icache_is_exception, mem_rd_req, icache_pc_suspend); end
    n_cmp++; if (icache_exception_cause !== 7'h08) begin n_err++; $display("FAIL exc_cause got %h want 08", icache_exception_cause); end
    n_cmp++; if (inst_for_buffer !== 64'd0) begin n_err++; $display("FAIL exc_inst got %h want 0", inst_for_buffer); end
    pi_exception_cause = 7'h00;
    tick();
  endtask

  task automatic test_flush;
    fetch(32'h1C000010, 1'b0, 1'b0);
    burst(32'hC0, 32'hC1, 32'hC2, 32'hC3, 2);
    n_cmp++; if ({icache_inst_valid, icache_pc_suspend} !== 2'b01) begin n_err++; $display("FAIL flush_resp got v=%b susp=%b want 01", icache_inst_valid, icache_pc_suspend); end
    tick();
    n_cmp++; if ({icache_inst_valid, icache_pc_suspend} !== 2'b00) begin n_err++; $display("FAIL flush_idle got v=%b susp=%b want 00", icache_inst_valid, icache_pc_suspend); end
    fetch(32'h1C000010, 1'b0, 1'b0);
    n_cmp++; if ({icache_inst_valid, mem_rd_req} !== 2'b10 || inst_for_buffer[0] !== 32'hC0) begin n_err++; $display("FAIL flush_rehit got v=%b req=%b inst=%h want 10 c0", icache_inst_valid, mem_rd_req, inst_for_buffer[0]); end
    fetch(32'h1C000014, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    n_cmp++; if (icache_inst_valid !== 1'b0) begin n_err++; $display("FAIL flush_hit got %b want 0", icache_inst_valid); end
    pi_pc = 32'h1C000018;
    inst_rreq_to_icache = 1'b1;
    tick();
    inst_rreq_to_icache = 1'b0;
    flush = 1'b0;
    #1;
    n_cmp++; if (icache_inst_valid !== 1'b1 || inst_for_buffer !== {32'hC3, 32'hC2}) begin n_err++; $display("FAIL flush_newreq got v=%b inst=%h want 1 c3/c2", icache_inst_valid, inst_for_buffer); end
    tick();
  endtask

  task automatic test_conflict_reset;
    fetch(32'h1C000000, 1'b0, 1'b0);
    burst(32'hD0, 32'hD1, 32'hD2, 32'hD3, -1);
    tick();
    fetch(32'h1C000400, 1'b0, 1'b0);
    n_cmp++; if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h1C000400) begin n_err++; $display("FAIL evict_req got req=%b addr=%h want 1 1c000400", mem_rd_req, mem_rd_addr); end
    burst(32'hE0, 32'hE1, 32'hE2, 32'hE3, -1);
    n_cmp++; if (icache_inst_valid !== 1'b1 || inst_for_buffer !== {32'hE1, 32'hE0}) begin n_err++; $display("FAIL evict_inst got v=%b inst=%h want 1 e1/e0", icache_inst_valid, inst_for_buffer); end
    tick();
    fetch(32'h1C000000, 1'b0, 1'b0);
    n_cmp++; if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h1C000000) begin n_err++; $display("FAIL evict_remiss got req=%b addr=%h want 1 1c000000", mem_rd_req, mem_rd_addr); end
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 32'hF0;
    tick();
    cpu_rst = 1'b0; mem_rdata = 32'hF1;
    tick();
    n_cmp++; if ({icache_pc_suspend, icache_inst_valid, mem_rd_req, mem_rd_addr} !== 35'd0) begin n_err++; $display("FAIL rst_mid got susp=%b v=%b req=%b addr=%h want 0", icache_pc_suspend, icache_inst_valid, mem_rd_req, mem_rd_addr); end
    n_cmp++; if ({pc_for_buffer, inst_for_buffer} !== 128'd0) begin n_err++; $display("FAIL rst_fields got %h %h want 0", pc_for_buffer, inst_for_buffer); end
    cpu_rst = 1'b1; mem_rdata = 32'hF2; mem_rdata_last = 1'b1;
    tick();
    mem_rdata_valid = 1'b0; mem_rdata_last = 1'b0;
    n_cmp++; if ({icache_inst_valid, icache_pc_suspend} !== 2'b00) begin n_err++; $display("FAIL rst_stray_beat got v=%b susp=%b want 00", icache_inst_valid, icache_pc_suspend); end
    fetch(32'h1C000400, 1'b0, 1'b0);
    n_cmp++; if (mem_rd_req !== 1'b1) begin n_err++; $display("FAIL rst_invalidate got req=%b want 1", mem_rd_req); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_uncached();
    test_exception();
    test_flush();
    test_conflict_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
